mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. Non-memory ops pass straight through. Loads and stores run as a sequence of byte transfers on the 8-bit memory-controller port, and the stage holds the pipeline through `stall[Stall_MEM]` until the access completes.

## Interface
- `ADDR_WIDTH`, 32, width of `ram_addr` and `mc_addr`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_rd_addr`  in  5  destination register, from EX/MEM.
- `mem_rd_enable`  in  1  destination write enable.
- `mem_rd_data`  in  32  ALU result for non-memory ops; store data for stores.
- `mem_aluop`  in  `AluOpBus`  operation.
- `mem_ram_addr`  in  ADDR_WIDTH  effective address for loads and stores.
- `wb_rd_addr`  out  5  to MEM/WB.
- `wb_rd_enable`  out  1  to MEM/WB.
- `wb_rd_data`  out  32  to MEM/WB; also the forwarding source for ID.
- `stall_req_mem`  out  1  to the stall controller, which drives `stall[Stall_MEM]`.
- `mc_req`  out  1  byte-transfer request.
- `mc_we`  out  1  1 = write, 0 = read.
- `mc_addr`  out  ADDR_WIDTH  byte address.
- `mc_wdata`  out  8  write byte.
- `mc_rdata`  in  8  read byte; valid when `mc_ready` is high.
- `mc_ready`  in  1  the transfer completes on the clock edge where `mc_req && mc_ready`.

## Operation
- Classes of op:
  - Memory ops: `EX_LB`, `EX_LH`, `EX_LW`, `EX_LBU`, `EX_LHU`, `EX_SB`, `EX_SH`, `EX_SW`.
  - Everything else, including `EX_NOP`, is pass-through: `wb_*` = `mem_*` combinationally, `stall_req_mem` = 0.
- Byte count is 1 for B, 2 for H and 4 for W. Byte k goes to address `mem_ram_addr + k`, mod 2^ADDR_WIDTH, so the address wraps. Data is little-endian. Misaligned addresses are legal; no trap is raised.
- FSM states:
  - IDLE:
    - Memory op present: `stall_req_mem` = 1, clear the byte counter `cnt` and the assembly register `buf`, then go to ACCESS.
    - Otherwise: pass-through.
  - ACCESS:
    - Outputs: `stall_req_mem` = 1, `mc_req` = 1, `mc_addr` = base + `cnt`, `mc_we` = store, `mc_wdata` = `mem_rd_data[8*cnt +: 8]`.
    - On each completed transfer: a load writes `mc_rdata` into `buf[8*cnt +: 8]`, and `cnt` increments.
    - After the last byte completes, go to DONE.
  - DONE:
    - `stall_req_mem` = 0 and `mc_req` = 0.
    - Loads: `wb_rd_data` = `buf` sign- or zero-extended per op. `wb_rd_addr` and `wb_rd_enable` pass through.
    - Stores: `wb_rd_enable` = 0 and `wb_rd_data` = 0.
    - Always go to IDLE on the next edge.
- While the stage is in IDLE→ACCESS, `wb_rd_enable` = 0, so MEM/WB never latches a partial result.
- Inputs are stable from IDLE through DONE, because EX/MEM holds while `stall[Stall_MEM]` is high. They change on the edge that ends DONE.
- If `rst` is high, all outputs are combinationally 0. On the next edge the state returns to IDLE and `cnt` and `buf` clear. Reset in the middle of a transfer abandons it; no completion is reported.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Pass-through ops: zero added latency, no stall.
- Memory op of N bytes with `mc_ready` always high: 1 IDLE cycle + N ACCESS cycles + 1 DONE cycle. `stall_req_mem` is high for N+1 cycles, so LW stalls 5 cycles and LB stalls 2.
- `mc_ready` wait states extend ACCESS. While a request is waiting, `mc_addr`, `mc_we` and `mc_wdata` hold steady.
- `mc_ready` without `mc_req` is ignored.
- Back-to-back memory ops: DONE → IDLE picks up the next op with no extra bubble, and the previous op is never reissued.

## Structure
- Constants shared through `config.v`:
  - the `EX_*` load/store aluop encodings;
  - `AluOpBus`;
  - `Stall_MEM`;
  - the state encodings `MEM_IDLE`, `MEM_ACCESS` and `MEM_DONE`.
- One natural sub-module, `load_extend`: combinational mapping of (`aluop`, `buf`) to the extended 32-bit value.

## Test plan
- ADD result 0x12345678 to rd 5 → the same cycle shows `wb_rd_data` = 0x12345678, `wb_rd_addr` = 5, `wb_rd_enable` = 1, and no stall.
- LW at 0x100 with memory 0x78, 0x56, 0x34, 0x12 and ready every cycle → `mc_addr` runs 0x100..0x103. DONE shows 0x12345678, and stall is high for exactly 5 cycles.
- LB and LBU at 0x7, byte 0x80 → 0xFFFFFF80 and 0x00000080. LH at 0x3 with bytes 0x01, 0xF0 → 0xFFFFF001.
- SW of 0xDEADBEEF at 0x200 with 2 wait cycles per byte → writes EF, BE, AD, DE to 0x200..0x203. `mc_*` stay stable during the waits, and DONE shows `wb_rd_enable` = 0.
- SH at 0xFFFFFFFF → writes to 0xFFFFFFFF, then 0x00000000 (wrap).
- Reset asserted during the third byte of LW → the next cycle shows state IDLE, `mc_req` = 0 and all outputs 0. A following LB completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants for the memory-access stage of the RV32I pipeline:
//   - AluOpBus and the EX_* operation encodings (pass-through and load/store)
//   - Stall_MEM, the index of the MEM stage in the stall vector
//   - mem_state_e, the stage FSM encoding (MEM_IDLE / MEM_ACCESS / MEM_DONE)
//   - small decode helpers used by the stage and its load-extend sub-module
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int ALU_OP_WIDTH = 8;
    typedef logic [ALU_OP_WIDTH-1:0] AluOpBus;

    // Non-memory operations (pass straight through the stage)
    localparam AluOpBus EX_NOP  = 8'h00;
    localparam AluOpBus EX_ADD  = 8'h01;
    localparam AluOpBus EX_SUB  = 8'h02;
    localparam AluOpBus EX_AND  = 8'h03;
    localparam AluOpBus EX_OR   = 8'h04;
    localparam AluOpBus EX_XOR  = 8'h05;

    // Loads
    localparam AluOpBus EX_LB   = 8'h10;
    localparam AluOpBus EX_LH   = 8'h11;
    localparam AluOpBus EX_LW   = 8'h12;
    localparam AluOpBus EX_LBU  = 8'h13;
    localparam AluOpBus EX_LHU  = 8'h14;

    // Stores
    localparam AluOpBus EX_SB   = 8'h18;
    localparam AluOpBus EX_SH   = 8'h19;
    localparam AluOpBus EX_SW   = 8'h1A;

    // Position of the MEM stage in the pipeline stall vector
    localparam int STALL_WIDTH = 6;
    localparam int Stall_MEM   = 3;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

    function automatic logic is_load(input AluOpBus op);
        return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
               (op == EX_LBU) || (op == EX_LHU);
    endfunction

    function automatic logic is_store(input AluOpBus op);
        return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    endfunction

    function automatic logic is_mem_op(input AluOpBus op);
        return is_load(op) || is_store(op);
    endfunction

    // Index of the final byte of the access (byte count - 1). Non-memory ops
    // map to 0 so a stray op in ACCESS can never leave the counter spinning.
    function automatic logic [1:0] last_byte_idx(input AluOpBus op);
        logic [1:0] idx;
        case (op)
            EX_LH, EX_LHU, EX_SH: idx = 2'd1;
            EX_LW, EX_SW:         idx = 2'd3;
            default:              idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// -----------------------------------------------------------------------------
// mem_stage_load_extend
// Combinational sign/zero extension of the assembled load bytes.
// Ports:
//   i_aluop  in   AluOpBus  load operation selecting width and signedness
//   i_buf    in   32        little-endian assembled bytes (byte 0 in [7:0])
//   o_data   out  32        value to write back
// -----------------------------------------------------------------------------
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  AluOpBus     i_aluop,
    input  logic [31:0] i_buf,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_buf;
        case (i_aluop)
            EX_LB:   o_data = {{24{i_buf[7]}}, i_buf[7:0]};
            EX_LBU:  o_data = {24'd0, i_buf[7:0]};
            EX_LH:   o_data = {{16{i_buf[15]}}, i_buf[15:0]};
            EX_LHU:  o_data = {16'd0, i_buf[15:0]};
            EX_LW:   o_data = i_buf;
            default: o_data = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage RV32I pipeline. Non-memory ops pass
// straight from EX/MEM to MEM/WB. Loads and stores are broken into 1, 2 or 4
// byte transfers on an 8-bit memory-controller port while the stage requests a
// pipeline stall; EX/MEM holds its outputs for the whole access.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_rd_addr/enable/data  destination reg, write enable, ALU result / store data
//   mem_aluop                operation (AluOpBus)
//   mem_ram_addr             effective byte address of a load/store
//   wb_rd_addr/enable/data   to MEM/WB (wb_rd_data also feeds ID forwarding)
//   stall_req_mem            stall request to the stall controller
//   mc_req, mc_we, mc_addr,  byte-transfer request, direction, address and
//   mc_wdata                 write byte
//   mc_rdata, mc_ready       read byte and transfer-complete handshake
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            mem_rd_addr,
    input  logic                  mem_rd_enable,
    input  logic [31:0]           mem_rd_data,
    input  AluOpBus               mem_aluop,
    input  logic [ADDR_WIDTH-1:0] mem_ram_addr,
    output logic [4:0]            wb_rd_addr,
    output logic                  wb_rd_enable,
    output logic [31:0]           wb_rd_data,
    output logic                  stall_req_mem,
    output logic                  mc_req,
    output logic                  mc_we,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [7:0]            mc_wdata,
    input  logic [7:0]            mc_rdata,
    input  logic                  mc_ready
);

    mem_state_e  r_state;
    mem_state_e  w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;

    logic        w_is_mem;
    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_last_idx;
    logic        w_xfer_done;
    logic        w_start;
    logic [31:0] w_buf;
    logic [31:0] w_load_value;

    assign w_is_load  = is_load(mem_aluop);
    assign w_is_store = is_store(mem_aluop);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_last_idx = last_byte_idx(mem_aluop);

    // mc_req is high for the whole of ACCESS, so ready alone marks completion
    // there; ready seen in any other state is ignored.
    assign w_xfer_done = (r_state == MEM_ACCESS) && mc_ready;
    assign w_start     = (r_state == MEM_IDLE) && w_is_mem;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MEM_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            MEM_IDLE: begin
                if (w_is_mem) begin
                    w_state_next = MEM_ACCESS;
                    w_cnt_next   = 2'd0;
                end
            end
            MEM_ACCESS: begin
                if (w_xfer_done) begin
                    // The 2-bit counter wraps after a word; it is cleared
                    // again before the next access starts.
                    w_cnt_next = r_cnt + 2'd1;
                    if (r_cnt == w_last_idx) begin
                        w_state_next = MEM_DONE;
                    end
                end
            end
            MEM_DONE: begin
                w_state_next = MEM_IDLE;
            end
            default: begin
                w_state_next = MEM_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------- load assembly lanes
    // One byte lane per possible transfer; a lane captures mc_rdata only on
    // the completed transfer whose counter value selects it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane;

            always_ff @(posedge clk) begin
                if (rst || w_start) begin
                    r_lane <= 8'd0;
                end else if (w_xfer_done && w_is_load && (r_cnt == 2'(gi))) begin
                    r_lane <= mc_rdata;
                end
            end

            assign w_buf[gi*8 +: 8] = r_lane;
        end
    endgenerate

    mem_stage_load_extend u_load_extend (
        .i_aluop (mem_aluop),
        .i_buf   (w_buf),
        .o_data  (w_load_value)
    );

    // ------------------------------------------------------------- outputs
    always_comb begin
        wb_rd_addr    = 5'd0;
        wb_rd_enable  = 1'b0;
        wb_rd_data    = 32'd0;
        stall_req_mem = 1'b0;
        mc_req        = 1'b0;
        mc_we         = 1'b0;
        mc_addr       = '0;
        mc_wdata      = 8'd0;
        if (!rst) begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_is_mem) begin
                        // Write-back stays disabled until DONE so MEM/WB
                        // never latches a partial result.
                        stall_req_mem = 1'b1;
                    end else begin
                        wb_rd_addr   = mem_rd_addr;
                        wb_rd_enable = mem_rd_enable;
                        wb_rd_data   = mem_rd_data;
                    end
                end
                MEM_ACCESS: begin
                    stall_req_mem = 1'b1;
                    mc_req        = 1'b1;
                    mc_we         = w_is_store;
                    mc_addr       = mem_ram_addr + ADDR_WIDTH'(r_cnt);
                    mc_wdata      = mem_rd_data[{r_cnt, 3'b000} +: 8];
                end
                MEM_DONE: begin
                    wb_rd_addr = mem_rd_addr;
                    if (w_is_load) begin
                        wb_rd_enable = mem_rd_enable;
                        wb_rd_data   = w_load_value;
                    end
                end
                default: begin
                    stall_req_mem = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;
    logic [31:0] mem_rd_data;
    AluOpBus     mem_aluop;
    logic [31:0] mem_ram_addr;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_enable;
    logic [31:0] wb_rd_data;
    logic        stall_req_mem;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic [7:0]  mc_rdata;
    logic        mc_ready;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_enable (mem_rd_enable),
        .mem_rd_data   (mem_rd_data),
        .mem_aluop     (mem_aluop),
        .mem_ram_addr  (mem_ram_addr),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_enable  (wb_rd_enable),
        .wb_rd_data    (wb_rd_data),
        .stall_req_mem (stall_req_mem),
        .mc_req        (mc_req),
        .mc_we         (mc_we),
        .mc_addr       (mc_addr),
        .mc_wdata      (mc_wdata),
        .mc_rdata      (mc_rdata),
        .mc_ready      (mc_ready)
    );

    // Simple memory model: 256 bytes, reads are combinational on mc_addr.
    logic [7:0] tb_mem [256];
    int wait_cfg = 0;
    int wait_cnt = 0;
    assign mc_rdata = tb_mem[mc_addr[7:0]];
    assign mc_ready = (wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (mc_req && mc_ready) wait_cnt <= 0;
        else if (mc_req)        wait_cnt <= wait_cnt + 1;
    end

    wire [80:0] all_out = {wb_rd_addr, wb_rd_enable, wb_rd_data, stall_req_mem,
                           mc_req, mc_we, mc_addr, mc_wdata};

    int n_checks = 0;
    int n_pass   = 0;

    // Results collected by run_op
    int          r_stall, r_nx, r_unstable, r_partial;
    logic        done_ok, r_first_req, r_first_stall;
    logic [31:0] d_data;
    logic        d_en;
    logic [4:0]  d_addr;
    logic [31:0] x_addr  [8];
    logic        x_we    [8];
    logic [7:0]  x_wdata [8];

    task automatic drive_idle();
        mem_aluop     = EX_NOP;
        mem_rd_addr   = 5'd0;
        mem_rd_enable = 1'b0;
        mem_rd_data   = 32'd0;
        mem_ram_addr  = 32'd0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Presents one op just after a clock edge and follows it to its DONE cycle.
    task automatic run_op(input AluOpBus op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd,
                          input int waits);
        logic        have_prev;
        logic        first;
        logic [31:0] p_addr;
        logic        p_we;
        logic [7:0]  p_wdata;
        @(posedge clk); #1;
        mem_aluop = op; mem_ram_addr = addr; mem_rd_data = data;
        mem_rd_addr = rd; mem_rd_enable = 1'b1; wait_cfg = waits;
        r_stall = 0; r_nx = 0; r_unstable = 0; r_partial = 0; done_ok = 1'b0;
        have_prev = 1'b0; first = 1'b1;
        p_addr = 32'd0; p_we = 1'b0; p_wdata = 8'd0;
        for (int cyc = 0; cyc < 100 && !done_ok; cyc++) begin
            @(negedge clk);
            if (first) begin
                r_first_req = mc_req; r_first_stall = stall_req_mem; first = 1'b0;
            end
            if (have_prev && mc_req &&
                (mc_addr !== p_addr || mc_we !== p_we || mc_wdata !== p_wdata))
                r_unstable++;
            have_prev = mc_req && !mc_ready;
            p_addr = mc_addr; p_we = mc_we; p_wdata = mc_wdata;
            if (mc_req && mc_ready) begin
                if (r_nx < 8) begin
                    x_addr[r_nx] = mc_addr; x_we[r_nx] = mc_we; x_wdata[r_nx] = mc_wdata;
                end
                r_nx++;
            end
            if (stall_req_mem) begin
                r_stall++;
                if (wb_rd_enable) r_partial++;
            end else if (r_stall > 0) begin
                done_ok = 1'b1;
                d_data = wb_rd_data; d_en = wb_rd_enable; d_addr = wb_rd_addr;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_aluop = EX_ADD; mem_rd_addr = 5'd3; mem_rd_enable = 1'b1;
        mem_rd_data = 32'hA5A5A5A5; mem_ram_addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_out !== 81'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (all_out !== 81'd0) $display("FAIL reset_idle_nop: got %h want 0", all_out);
        else n_pass++;
        $display("reset: outputs %h", all_out);
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        mem_aluop = EX_ADD; mem_rd_data = 32'h12345678; mem_rd_addr = 5'd5; mem_rd_enable = 1'b1;
        #1;
        n_checks++;
        if ({wb_rd_data, wb_rd_addr, wb_rd_enable} !== {32'h12345678, 5'd5, 1'b1})
            $display("FAIL pass_add: got %h/%0d/%b want 12345678/5/1", wb_rd_data, wb_rd_addr, wb_rd_enable);
        else n_pass++;
        n_checks++;
        if ({stall_req_mem, mc_req} !== 2'b00)
            $display("FAIL pass_add_stall: got stall=%b req=%b want 0/0", stall_req_mem, mc_req);
        else n_pass++;
        $display("pass ADD: data=%h rd=%0d en=%b stall=%b", wb_rd_data, wb_rd_addr, wb_rd_enable, stall_req_mem);
        @(negedge clk);
        mem_aluop = EX_XOR; mem_rd_data = 32'hCAFEF00D; mem_rd_addr = 5'd31; mem_rd_enable = 1'b0;
        #1;
        n_checks++;
        if ({wb_rd_data, wb_rd_addr, wb_rd_enable, stall_req_mem} !== {32'hCAFEF00D, 5'd31, 1'b0, 1'b0})
            $display("FAIL pass_xor: got %h/%0d/%b/%b want cafef00d/31/0/0", wb_rd_data, wb_rd_addr, wb_rd_enable, stall_req_mem);
        else n_pass++;
        $display("pass XOR: data=%h rd=%0d en=%b", wb_rd_data, wb_rd_addr, wb_rd_enable);
        go_idle();
    endtask

    task automatic test_lw();
        tb_mem[8'h00] = 8'h78; tb_mem[8'h01] = 8'h56; tb_mem[8'h02] = 8'h34; tb_mem[8'h03] = 8'h12;
        run_op(EX_LW, 32'h100, 32'd0, 5'd7, 0);
        n_checks++;
        if (done_ok !== 1'b1) $display("FAIL lw_timeout: done=%b want 1", done_ok);
        else n_pass++;
        n_checks++;
        if (r_stall !== 5) $display("FAIL lw_stall: got %0d want 5", r_stall);
        else n_pass++;
        n_checks++;
        if (r_nx !== 4) $display("FAIL lw_nxfer: got %0d want 4", r_nx);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({x_addr[k], x_we[k]} !== {32'h100 + 32'(k), 1'b0})
                $display("FAIL lw_addr%0d: got %h we=%b want %h we=0", k, x_addr[k], x_we[k], 32'h100 + 32'(k));
            else n_pass++;
        end
        n_checks++;
        if ({d_data, d_addr, d_en} !== {32'h12345678, 5'd7, 1'b1})
            $display("FAIL lw_data: got %h/%0d/%b want 12345678/7/1", d_data, d_addr, d_en);
        else n_pass++;
        n_checks++;
        if (r_partial !== 0) $display("FAIL lw_partial_wb: got %0d want 0", r_partial);
        else n_pass++;
        $display("LW 0x100: data=%h stall=%0d xfers=%0d", d_data, r_stall, r_nx);
        go_idle();
    endtask

    task automatic test_lb_lh();
        tb_mem[8'h07] = 8'h80;
        run_op(EX_LB, 32'h7, 32'd0, 5'd1, 0);
        n_checks++;
        if ({done_ok, d_data, r_stall, r_nx} !== {1'b1, 32'hFFFFFF80, 32'd2, 32'd1})
            $display("FAIL lb: got done=%b data=%h stall=%0d nx=%0d want 1/ffffff80/2/1", done_ok, d_data, r_stall, r_nx);
        else n_pass++;
        $display("LB 0x7: data=%h stall=%0d", d_data, r_stall);
        run_op(EX_LBU, 32'h7, 32'd0, 5'd2, 0);
        n_checks++;
        if ({done_ok, d_data, r_stall} !== {1'b1, 32'h00000080, 32'd2})
            $display("FAIL lbu: got done=%b data=%h stall=%0d want 1/00000080/2", done_ok, d_data, r_stall);
        else n_pass++;
        $display("LBU 0x7: data=%h stall=%0d", d_data, r_stall);
        tb_mem[8'h03] = 8'h01; tb_mem[8'h04] = 8'hF0;
        run_op(EX_LH, 32'h3, 32'd0, 5'd3, 0);
        n_checks++;
        if ({done_ok, d_data, r_stall, x_addr[1]} !== {1'b1, 32'hFFFFF001, 32'd3, 32'h4})
            $display("FAIL lh: got done=%b data=%h stall=%0d a1=%h want 1/fffff001/3/4", done_ok, d_data, r_stall, x_addr[1]);
        else n_pass++;
        $display("LH 0x3: data=%h stall=%0d", d_data, r_stall);
        run_op(EX_LHU, 32'h3, 32'd0, 5'd4, 0);
        n_checks++;
        if ({done_ok, d_data} !== {1'b1, 32'h0000F001})
            $display("FAIL lhu: got done=%b data=%h want 1/0000f001", done_ok, d_data);
        else n_pass++;
        $display("LHU 0x3: data=%h", d_data);
        go_idle();
    endtask

    task automatic test_sw_waits();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        run_op(EX_SW, 32'h200, 32'hDEADBEEF, 5'd9, 2);
        n_checks++;
        if ({done_ok, r_nx, r_stall} !== {1'b1, 32'd4, 32'd13})
            $display("FAIL sw_count: got done=%b nx=%0d stall=%0d want 1/4/13", done_ok, r_nx, r_stall);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({x_addr[k], x_we[k], x_wdata[k]} !== {32'h200 + 32'(k), 1'b1, exp_b[k]})
                $display("FAIL sw_byte%0d: got %h we=%b d=%h want %h we=1 d=%h",
                         k, x_addr[k], x_we[k], x_wdata[k], 32'h200 + 32'(k), exp_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (r_unstable !== 0) $display("FAIL sw_stable: got %0d changes want 0", r_unstable);
        else n_pass++;
        n_checks++;
        if ({d_en, d_data} !== {1'b0, 32'd0})
            $display("FAIL sw_done_wb: got en=%b data=%h want 0/0", d_en, d_data);
        else n_pass++;
        $display("SW 0x200 waits=2: bytes %h %h %h %h stall=%0d", x_wdata[0], x_wdata[1], x_wdata[2], x_wdata[3], r_stall);
        wait_cfg = 0;
        go_idle();
    endtask

    task automatic test_sh_wrap();
        run_op(EX_SH, 32'hFFFFFFFF, 32'h0000A55A, 5'd0, 0);
        n_checks++;
        if ({done_ok, r_nx, x_addr[0], x_addr[1]} !== {1'b1, 32'd2, 32'hFFFFFFFF, 32'h0})
            $display("FAIL sh_wrap_addr: got done=%b nx=%0d %h %h want 1/2/ffffffff/00000000", done_ok, r_nx, x_addr[0], x_addr[1]);
        else n_pass++;
        n_checks++;
        if ({x_wdata[0], x_wdata[1]} !== 16'h5AA5)
            $display("FAIL sh_wrap_data: got %h %h want 5a a5", x_wdata[0], x_wdata[1]);
        else n_pass++;
        $display("SH 0xffffffff: %h<-%h %h<-%h", x_addr[0], x_wdata[0], x_addr[1], x_wdata[1]);
        go_idle();
    endtask

    task automatic test_back_to_back();
        int stray;
        tb_mem[8'h20] = 8'h11; tb_mem[8'h21] = 8'h22;
        run_op(EX_LBU, 32'h20, 32'd0, 5'd10, 0);
        n_checks++;
        if ({done_ok, d_data, r_nx} !== {1'b1, 32'h11, 32'd1})
            $display("FAIL b2b_first: got done=%b data=%h nx=%0d want 1/11/1", done_ok, d_data, r_nx);
        else n_pass++;
        run_op(EX_LBU, 32'h21, 32'd0, 5'd11, 0);
        n_checks++;
        if ({r_first_stall, r_first_req, done_ok, d_data, r_nx, x_addr[0], r_stall} !==
            {1'b1, 1'b0, 1'b1, 32'h22, 32'd1, 32'h21, 32'd2})
            $display("FAIL b2b_second: got st=%b rq=%b done=%b data=%h nx=%0d a=%h stall=%0d want 1/0/1/22/1/21/2",
                     r_first_stall, r_first_req, done_ok, d_data, r_nx, x_addr[0], r_stall);
        else n_pass++;
        go_idle();
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mc_req || stall_req_mem) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL b2b_reissue: got %0d busy cycles want 0", stray);
        else n_pass++;
        $display("back-to-back LBU: second data=%h, idle busy cycles=%0d", d_data, stray);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        mem_aluop = EX_LW; mem_ram_addr = 32'h100; mem_rd_addr = 5'd6; mem_rd_enable = 1'b1;
        mem_rd_data = 32'd0; wait_cfg = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({mc_req, mc_addr} !== {1'b1, 32'h102})
            $display("FAIL rstmid_third: got req=%b addr=%h want 1/00000102", mc_req, mc_addr);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 81'd0) $display("FAIL rstmid_comb: got %h want 0", all_out);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (all_out !== 81'd0) $display("FAIL rstmid_after: got %h want 0", all_out);
        else n_pass++;
        $display("reset mid-LW: outputs after %h", all_out);
        tb_mem[8'h07] = 8'h5A;
        run_op(EX_LB, 32'h7, 32'd0, 5'd12, 0);
        n_checks++;
        if ({r_first_req, done_ok, d_data, d_addr, r_nx, x_addr[0], r_stall} !==
            {1'b0, 1'b1, 32'h5A, 5'd12, 32'd1, 32'h7, 32'd2})
            $display("FAIL rstmid_lb: got rq=%b done=%b data=%h rd=%0d nx=%0d a=%h stall=%0d want 0/1/5a/12/1/7/2",
                     r_first_req, done_ok, d_data, d_addr, r_nx, x_addr[0], r_stall);
        else n_pass++;
        $display("LB after reset: data=%h stall=%0d", d_data, r_stall);
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        test_reset();
        test_passthrough();
        test_lw();
        test_lb_lh();
        test_sw_waits();
        test_sh_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
